// File: rtl/uc_multiciclo_io.sv
// uc_multiciclo_io: opcode decode plus synchronised I/O handshake FSM with optional timeout and halt
module uc_multiciclo_io #(
    parameter int INSTR_W     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int IO_TIMEOUT  = 0,
    parameter int CNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instrucao,
    input  logic               sinal,
    output logic [2:0]         desvio,
    output logic               memReg,
    output logic               escreveMem,
    output logic [1:0]         origULA,
    output logic               escreveReg,
    output logic [1:0]         opULA,
    output logic [1:0]         ext,
    output logic               out,
    output logic               in,
    output logic               stop,
    output logic               jal,
    output logic [1:0]         estado,
    output logic               erro_io,
    output logic               halted
);
    typedef enum logic [1:0] {RUN = 2'd0, IO_WAIT = 2'd1, IO_DONE = 2'd2, HALT = 2'd3} state_t;

    // control vector layout: desvio, memReg, escreveMem, origULA, escreveReg, opULA, ext, out, in, stop, jal
    localparam logic [15:0] WAIT_OUT = 16'b000_0_0_00_0_00_00_1_0_1_0;
    localparam logic [15:0] WAIT_IN  = 16'b000_0_0_00_0_10_00_0_1_1_0;
    localparam logic [15:0] DONE_IN  = 16'b000_0_0_01_1_11_10_0_0_0_0;
    localparam logic [15:0] HALT_CTL = 16'b000_0_0_00_0_00_00_0_0_1_0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                 state, state_n;
    logic [5:0]             opcode;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_sync, s_sync_d, rise, timeout, abort, skip;
    logic                   is_io, is_in;
    logic [CNT_W-1:0]       cnt;
    logic [15:0]            run_ctl, ctl;
    logic                   unused_low;

    assign opcode     = instrucao[INSTR_W-1 -: 6];
    assign unused_low = ^instrucao[INSTR_W-7:0];
    assign is_io      = (opcode == 6'h0E) || (opcode == 6'h0F);
    assign is_in      = opcode == 6'h0F;
    assign s_sync     = sync[SYNC_STAGES-1];
    assign rise       = s_sync & ~s_sync_d;
    assign timeout    = (IO_TIMEOUT != 0) && (cnt == CNT_LAST);
    assign abort      = (state == IO_WAIT) && !rise && timeout;

    // single-cycle decode of the current opcode as seen in RUN
    always_comb begin
        run_ctl = '0;
        case (opcode)
            6'h00: run_ctl = 16'b000_0_0_00_1_01_00_0_0_0_0;
            6'h01: run_ctl = 16'b000_0_0_01_1_11_00_0_0_0_0;
            6'h02: run_ctl = 16'b000_0_0_01_1_10_00_0_0_0_0;
            6'h03: run_ctl = 16'b001_0_0_00_0_00_01_0_0_0_0;
            6'h04: run_ctl = 16'b011_0_0_00_0_00_01_0_0_0_0;
            6'h05: run_ctl = 16'b010_0_0_10_0_10_00_0_0_0_0;
            6'h06: run_ctl = 16'b100_0_0_10_0_10_00_0_0_0_0;
            6'h07: run_ctl = 16'b101_0_0_10_0_11_00_0_0_0_0;
            6'h08: run_ctl = 16'b101_0_0_10_0_10_00_0_0_0_0;
            6'h09: run_ctl = 16'b110_0_0_10_0_11_00_0_0_0_0;
            6'h0A: run_ctl = 16'b110_0_0_10_0_10_00_0_0_0_0;
            6'h0B: run_ctl = 16'b000_1_0_01_1_11_00_0_0_0_0;
            6'h0C: run_ctl = 16'b000_0_1_01_0_11_00_0_0_0_0;
            6'h0D: run_ctl = 16'b001_0_0_00_0_00_01_0_0_0_1;
            6'h0E: run_ctl = WAIT_OUT;
            6'h0F: run_ctl = WAIT_IN;
            6'h11: run_ctl = HALT_CTL;
            default: run_ctl = '0;
        endcase
    end

    // next state and per-state control outputs; the cycle after a timeout is a bubble so the PC moves past the aborted I/O
    always_comb begin
        ctl     = '0;
        state_n = state;
        case (state)
            RUN: begin
                ctl     = skip ? '0 : run_ctl;
                state_n = skip ? RUN : is_io ? IO_WAIT : (opcode == 6'h11) ? HALT : RUN;
            end
            IO_WAIT: begin
                ctl     = is_in ? WAIT_IN : WAIT_OUT;
                state_n = rise ? IO_DONE : timeout ? RUN : IO_WAIT;
            end
            IO_DONE: begin
                ctl     = is_in ? DONE_IN : '0;
                state_n = RUN;
            end
            default: ctl = HALT_CTL;
        endcase
        if (reset) ctl = '0;
    end

    assign {desvio, memReg, escreveMem, origULA, escreveReg, opULA, ext, out, in, stop, jal} = ctl;
    assign estado = state;
    assign halted = (state == HALT) && !reset;

    // synchroniser chain and edge-detect register for the asynchronous strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            sync     <= '0;
            s_sync_d <= 1'b0;
        end else begin
            sync     <= SYNC_STAGES'({sync, sinal});
            s_sync_d <= s_sync;
        end
    end

    // wait counter: counts IO_WAIT cycles, saturates, cleared on every exit from IO_WAIT
    always_ff @(posedge clock) begin
        if (reset) cnt <= '0;
        else cnt <= (state != IO_WAIT || rise || timeout) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end

    // state register with sticky timeout flag and post-abort bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            erro_io <= 1'b0;
            skip    <= 1'b0;
        end else begin
            state   <= state_n;
            erro_io <= erro_io | abort;
            skip    <= abort;
        end
    end
endmodule

// File: tb/tb_uc_multiciclo_io.sv
// tb_uc_multiciclo_io: directed and randomized checks of uc_multiciclo_io against a behavioural model
module tb_uc_multiciclo_io;
    localparam int W   = 32;
    localparam int S   = 2;
    localparam int TO1 = 5;

    typedef struct packed {
        logic [2:0] desvio;
        logic       mem_reg;
        logic       esc_mem;
        logic [1:0] orig;
        logic       esc_reg;
        logic [1:0] op_ula;
        logic [1:0] ext;
        logic       o;
        logic       i;
        logic       stop;
        logic       jal;
        logic       halted;
    } ctl_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         sinal = 1'b0;
    logic [W-1:0] instrucao = '0;

    logic [2:0] q_desvio  [2];
    logic       q_mem_reg [2];
    logic       q_esc_mem [2];
    logic [1:0] q_orig    [2];
    logic       q_esc_reg [2];
    logic [1:0] q_op_ula  [2];
    logic [1:0] q_ext     [2];
    logic       q_out     [2];
    logic       q_in      [2];
    logic       q_stop    [2];
    logic       q_jal     [2];
    logic [1:0] q_estado  [2];
    logic       q_erro    [2];
    logic       q_halted  [2];

    int asserts = 0;
    int fails   = 0;

    // model state per DUT (DUT 1 has the timeout enabled): 0 run, 1 waiting, 2 done, 3 halted
    int m_mode [2];
    int m_wait [2];
    bit m_err  [2];
    bit m_skip [2];
    bit hist [$];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : gd
        uc_multiciclo_io #(.INSTR_W(W), .SYNC_STAGES(S), .IO_TIMEOUT(g == 0 ? 0 : TO1), .CNT_W(16)) dut (
            .clock(clock), .reset(reset), .instrucao(instrucao), .sinal(sinal),
            .desvio(q_desvio[g]), .memReg(q_mem_reg[g]), .escreveMem(q_esc_mem[g]), .origULA(q_orig[g]),
            .escreveReg(q_esc_reg[g]), .opULA(q_op_ula[g]), .ext(q_ext[g]), .out(q_out[g]), .in(q_in[g]),
            .stop(q_stop[g]), .jal(q_jal[g]), .estado(q_estado[g]), .erro_io(q_erro[g]), .halted(q_halted[g])
        );
    end

    function automatic logic [5:0] opc();
        return instrucao[W-1 -: 6];
    endfunction

    function automatic ctl_t act(int d);
        ctl_t a;
        a.desvio = q_desvio[d];  a.mem_reg = q_mem_reg[d]; a.esc_mem = q_esc_mem[d];
        a.orig = q_orig[d];      a.esc_reg = q_esc_reg[d]; a.op_ula = q_op_ula[d];
        a.ext = q_ext[d];        a.o = q_out[d];           a.i = q_in[d];
        a.stop = q_stop[d];      a.jal = q_jal[d];         a.halted = q_halted[d];
        return a;
    endfunction

    function automatic ctl_t decode(logic [5:0] op);
        ctl_t c;
        c = '0;
        case (op)
            6'h00: begin c.esc_reg = 1; c.op_ula = 2'b01; end
            6'h01: begin c.orig = 2'b01; c.esc_reg = 1; c.op_ula = 2'b11; end
            6'h02: begin c.orig = 2'b01; c.esc_reg = 1; c.op_ula = 2'b10; end
            6'h03: begin c.desvio = 3'b001; c.ext = 2'b01; end
            6'h04: begin c.desvio = 3'b011; c.ext = 2'b01; end
            6'h05: begin c.desvio = 3'b010; c.orig = 2'b10; c.op_ula = 2'b10; end
            6'h06: begin c.desvio = 3'b100; c.orig = 2'b10; c.op_ula = 2'b10; end
            6'h07: begin c.desvio = 3'b101; c.orig = 2'b10; c.op_ula = 2'b11; end
            6'h08: begin c.desvio = 3'b101; c.orig = 2'b10; c.op_ula = 2'b10; end
            6'h09: begin c.desvio = 3'b110; c.orig = 2'b10; c.op_ula = 2'b11; end
            6'h0A: begin c.desvio = 3'b110; c.orig = 2'b10; c.op_ula = 2'b10; end
            6'h0B: begin c.mem_reg = 1; c.orig = 2'b01; c.esc_reg = 1; c.op_ula = 2'b11; end
            6'h0C: begin c.esc_mem = 1; c.orig = 2'b01; c.op_ula = 2'b11; end
            6'h0D: begin c.desvio = 3'b001; c.ext = 2'b01; c.jal = 1; end
            6'h0E: begin c.stop = 1; c.o = 1; end
            6'h0F: begin c.stop = 1; c.i = 1; c.op_ula = 2'b10; end
            6'h11: c.stop = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t expect_ctl(int d);
        ctl_t c;
        c = '0;
        if (reset) return c;
        case (m_mode[d])
            0: if (!m_skip[d]) c = decode(opc());
            1: begin
                c.stop = 1;
                if (opc() == 6'h0F) begin c.i = 1; c.op_ula = 2'b10; end
                else c.o = 1;
            end
            2: if (opc() == 6'h0F) begin c.esc_reg = 1; c.ext = 2'b10; c.op_ula = 2'b11; c.orig = 2'b01; end
            default: begin c.stop = 1; c.halted = 1; end
        endcase
        return c;
    endfunction

    // value of sinal as sampled k edges before the most recent one
    function automatic bit sample_ago(int k);
        return (hist.size() > k) ? hist[hist.size() - 1 - k] : 1'b0;
    endfunction

    task automatic model_step();
        bit r;
        r = sample_ago(S - 1) & ~sample_ago(S);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_mode[d] = 0; m_wait[d] = 0; m_err[d] = 0; m_skip[d] = 0;
            end else if (m_mode[d] == 0) begin
                if (m_skip[d]) m_skip[d] = 0;
                else if (opc() == 6'h0E || opc() == 6'h0F) begin m_mode[d] = 1; m_wait[d] = 0; end
                else if (opc() == 6'h11) m_mode[d] = 3;
            end else if (m_mode[d] == 1) begin
                m_wait[d]++;
                if (r) m_mode[d] = 2;
                else if (d == 1 && m_wait[d] == TO1) begin m_mode[d] = 0; m_err[d] = 1; m_skip[d] = 1; end
            end else if (m_mode[d] == 2) m_mode[d] = 0;
        end
        if (reset) hist.delete();
        else begin
            hist.push_back(sinal);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    // one clock: compare both DUTs to the model at the falling edge, then advance the model
    task automatic step();
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            asserts++;
            if (act(d) !== expect_ctl(d)) begin
                fails++;
                $display("FAIL ctl dut%0d t=%0t op=%02h: got %h, expected %h", d, $time, opc(), act(d), expect_ctl(d));
            end
            if (!reset) begin
                asserts++;
                if (q_estado[d] !== 2'(m_mode[d]) || q_erro[d] !== m_err[d]) begin
                    fails++;
                    $display("FAIL state dut%0d t=%0t: estado/erro %0d/%0b, expected %0d/%0b",
                             d, $time, q_estado[d], q_erro[d], m_mode[d], m_err[d]);
                end
            end
        end
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1; sinal = 0; instrucao = '0;
        step(); step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; sinal = 1; instrucao = {6'h01, 26'h0};
        step(); step();
        for (int d = 0; d < 2; d++) begin
            asserts++;
            if (act(d) !== ctl_t'(0)) begin fails++; $display("FAIL reset_outputs dut%0d: got %h, expected 0", d, act(d)); end
        end
        reset = 0; sinal = 0; instrucao = '0;
        #1;
        asserts++;
        if (q_estado[0] !== 2'd0 || q_erro[0] !== 1'b0 || q_halted[0] !== 1'b0 || q_esc_reg[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: estado=%0d erro=%0b halted=%0b escreveReg=%0b, expected 0 0 0 1",
                     q_estado[0], q_erro[0], q_halted[0], q_esc_reg[0]);
        end
        step();
    endtask

    task automatic test_decode();
        logic [5:0] ops [16] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h10, 6'h3F};
        logic [5:0] op;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            op = (k < 16) ? ops[k] : 6'($urandom_range(18, 62));
            instrucao = {op, 26'($urandom)};
            #1;
            asserts++;
            if (act(0) !== decode(op) || q_estado[0] !== 2'd0) begin
                fails++;
                $display("FAIL decode op=%02h: got %h estado %0d, expected %h estado 0", op, act(0), q_estado[0], decode(op));
            end
            step();
        end
    endtask

    task automatic test_in();
        int  n_stop = 0;
        int  n_wr   = 0;
        bit  done   = 0;
        do_reset();
        instrucao = {6'h0F, 26'($urandom)};
        for (int c = 0; c < 40 && !done; c++) begin
            sinal = (c == 11);
            #1;
            if (q_estado[0] == 2'd2) done = 1;
            else begin
                n_stop += int'(q_stop[0] & q_in[0]);
                n_wr   += int'(q_esc_reg[0]);
                step();
            end
        end
        asserts++;
        if (!done) begin fails++; $display("FAIL in_done_reached: no IO_DONE within 40 cycles"); end
        asserts++;
        if (n_stop != 1 + 10 + S + 1 || n_wr != 0) begin
            fails++;
            $display("FAIL in_wait_len: stop cycles %0d writes %0d, expected %0d and 0", n_stop, n_wr, 1 + 10 + S + 1);
        end
        asserts++;
        if (q_esc_reg[0] !== 1'b1 || q_ext[0] !== 2'b10 || q_orig[0] !== 2'b01 || q_op_ula[0] !== 2'b11 || q_stop[0] !== 1'b0) begin
            fails++;
            $display("FAIL in_done_ctl: got %h, expected escreveReg=1 ext=10 origULA=01 opULA=11 stop=0", act(0));
        end
        step();
        instrucao = {6'h10, 26'h0};
        #1;
        asserts++;
        if (q_estado[0] !== 2'd0) begin fails++; $display("FAIL in_back_to_run: estado %0d, expected 0", q_estado[0]); end
        step();
    endtask

    task automatic test_out();
        bit done = 0;
        int n_ok = 0;
        do_reset();
        sinal = 1; instrucao = {6'h10, 26'h0};
        repeat (4) step();
        instrucao = {6'h0E, 26'($urandom)};
        step();
        for (int k = 0; k < 6; k++) begin
            #1;
            n_ok += int'(q_estado[0] == 2'd1 && q_out[0] == 1'b1 && q_stop[0] == 1'b1);
            step();
        end
        asserts++;
        if (n_ok != 6) begin fails++; $display("FAIL out_held_high: waiting cycles %0d, expected 6", n_ok); end
        sinal = 0;
        repeat (3) step();
        sinal = 1;
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            if (q_estado[0] == 2'd2) done = 1;
            else step();
        end
        asserts++;
        if (!done) begin fails++; $display("FAIL out_done_reached: no IO_DONE within 10 cycles"); end
        asserts++;
        if (act(0) !== ctl_t'(0)) begin fails++; $display("FAIL out_done_ctl: got %h, expected 0", act(0)); end
        step();
        sinal = 0; instrucao = {6'h10, 26'h0};
        #1;
        asserts++;
        if (q_estado[0] !== 2'd0) begin fails++; $display("FAIL out_back_to_run: estado %0d, expected 0", q_estado[0]); end
        step();
    endtask

    task automatic test_timeout();
        int n_wr   = 0;
        int n_wait = 0;
        do_reset();
        instrucao = {6'h0F, 26'($urandom)}; sinal = 0;
        for (int c = 0; c <= TO1; c++) begin
            #1;
            n_wr   += int'(q_esc_reg[1]);
            n_wait += int'(q_estado[1] == 2'd1);
            step();
        end
        #1;
        asserts++;
        if (n_wait != TO1) begin fails++; $display("FAIL timeout_len: waiting cycles %0d, expected %0d", n_wait, TO1); end
        asserts++;
        if (q_estado[1] !== 2'd0 || q_erro[1] !== 1'b1 || q_stop[1] !== 1'b0 || q_esc_reg[1] !== 1'b0 || n_wr != 0) begin
            fails++;
            $display("FAIL timeout_abort: estado=%0d erro=%0b stop=%0b escreveReg=%0b writes=%0d, expected 0 1 0 0 0",
                     q_estado[1], q_erro[1], q_stop[1], q_esc_reg[1], n_wr);
        end
        step();
        for (int k = 0; k < 6; k++) begin
            instrucao = {6'($urandom_range(0, 13)), 26'($urandom)};
            #1;
            asserts++;
            if (q_erro[1] !== 1'b1) begin fails++; $display("FAIL timeout_sticky: erro_io %0b, expected 1", q_erro[1]); end
            step();
        end
        reset = 1;
        step();
        reset = 0;
        #1;
        asserts++;
        if (q_erro[1] !== 1'b0) begin fails++; $display("FAIL timeout_clear: erro_io %0b, expected 0", q_erro[1]); end
        step();
    endtask

    task automatic test_halt();
        do_reset();
        instrucao = {6'h11, 26'($urandom)};
        #1;
        asserts++;
        if (q_stop[0] !== 1'b1 || q_halted[0] !== 1'b0 || q_estado[0] !== 2'd0) begin
            fails++;
            $display("FAIL halt_entry: stop=%0b halted=%0b estado=%0d, expected 1 0 0", q_stop[0], q_halted[0], q_estado[0]);
        end
        step();
        for (int k = 0; k < 10; k++) begin
            instrucao = $urandom;
            sinal = 1'($urandom);
            #1;
            for (int d = 0; d < 2; d++) begin
                asserts++;
                if (q_estado[d] !== 2'd3 || q_halted[d] !== 1'b1 || q_stop[d] !== 1'b1) begin
                    fails++;
                    $display("FAIL halt_hold dut%0d: estado=%0d halted=%0b stop=%0b, expected 3 1 1", d, q_estado[d], q_halted[d], q_stop[d]);
                end
            end
            step();
        end
        reset = 1;
        step();
        reset = 0; sinal = 0; instrucao = '0;
        #1;
        asserts++;
        if (q_estado[0] !== 2'd0 || q_halted[0] !== 1'b0) begin
            fails++;
            $display("FAIL halt_exit: estado=%0d halted=%0b, expected 0 0", q_estado[0], q_halted[0]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        do_reset();
        instrucao = {6'h0F, 26'($urandom)}; sinal = 0;
        repeat (4) step();
        sinal = 1;
        step();
        reset = 1; sinal = 0;
        #1;
        asserts++;
        if (act(0) !== ctl_t'(0)) begin fails++; $display("FAIL mid_reset_outputs: got %h, expected 0", act(0)); end
        step();
        reset = 0; instrucao = {6'h01, 26'($urandom)};
        #1;
        asserts++;
        if (q_estado[0] !== 2'd0 || q_erro[0] !== 1'b0 || act(0) !== decode(6'h01)) begin
            fails++;
            $display("FAIL mid_reset_run: estado=%0d erro=%0b ctl=%h, expected 0 0 %h", q_estado[0], q_erro[0], act(0), decode(6'h01));
        end
        for (int k = 0; k < 6; k++) begin
            step();
            n_done += int'(q_estado[0] == 2'd2);
        end
        asserts++;
        if (n_done != 0) begin fails++; $display("FAIL mid_reset_no_done: IO_DONE cycles %0d, expected 0", n_done); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (m_mode[0] == 3 || m_mode[1] == 3) reset = 1;
            else reset = ($urandom_range(0, 79) == 0);
            if (m_mode[0] == 0 && m_mode[1] == 0)
                instrucao = {($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'($urandom_range(0, 18)), 26'($urandom)};
            if ($urandom_range(0, 3) == 0) sinal = ~sinal;
            step();
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_in();
        test_out();
        test_timeout();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
